// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: serial line in, received byte and status flags out.
interface uart_rx_sampler_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       busy;
   logic       frame_err;
   logic       parity_err;
   modport master (output rx, input data, valid, busy, frame_err, parity_err);
   modport slave  (input rx, output data, valid, busy, frame_err, parity_err);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver sampling mid-bit behind a 2-flop synchroniser.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx_sampler #(
   parameter int CLKS_PER_BIT = 5208
) (
   input logic clk,
   input logic reset,
   uart_rx_sampler_if.slave port
);
   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`ifdef UART_RX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif
   state_t state, state_n;
   logic [1:0] sync;
   logic rx_s, bit_end, half_end;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift;
   assign rx_s = sync[1];
   assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
   assign half_end = cnt == CW'(HALF_BIT - 1);
   assign port.busy = state != IDLE;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      state_n = rx_s ? IDLE : START;
         START:     state_n = half_end ? (rx_s ? IDLE : DATA) : START;
         DATA:      state_n = (bit_end && bit_idx == 3'd7) ? AFTER_DATA : DATA;
         PARITY:    state_n = bit_end ? STOP : PARITY;
         STOP:      state_n = bit_end ? (rx_s ? IDLE : WAIT_IDLE) : STOP;
         WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
         default:   state_n = IDLE;
      endcase
   end
   // Counter restarts on every transition and at each bit boundary inside DATA.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sync <= 2'b11;
         state <= IDLE;
         cnt <= '0;
         bit_idx <= '0;
         shift <= '0;
         port.data <= '0;
         port.valid <= 1'b0;
         port.frame_err <= 1'b0;
      end else begin
         sync <= {sync[0], port.rx};
         state <= state_n;
         cnt <= (state_n != state || bit_end || state inside {IDLE, WAIT_IDLE}) ? '0 : cnt + CW'(1);
         bit_idx <= (state == START) ? 3'd0 : (state == DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;
         if (state == DATA && bit_end) shift[bit_idx] <= rx_s;
         port.valid <= state == STOP && bit_end;
         if (state == STOP && bit_end) begin
            port.data <= shift;
            port.frame_err <= ~rx_s;
         end
      end
`ifdef UART_RX_PARITY_EN
   logic par;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         par <= 1'b0;
         port.parity_err <= 1'b0;
      end else begin
         if (state == PARITY && bit_end) par <= rx_s;
         if (state == STOP && bit_end) port.parity_err <= par ^ (^shift);
      end
`else
   assign port.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed and random UART frames checked against a frame-level model.
module tb_uart_rx_sampler;
   localparam int CPB = 16;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
   localparam bit PAR = 1;
`else
   localparam int NB = 10;
   localparam bit PAR = 0;
`endif
   typedef struct {
      logic [7:0] d;
      logic fe;
      logic pe;
      logic bz;
      longint t;
   } ev_t;
   logic clk = 0;
   logic reset = 1;
   int compared = 0;
   int mismatched = 0;
   longint cyc = 0;
   ev_t got[$];
   ev_t exp_q[$];
   uart_rx_sampler_if bus ();
   uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .reset(reset), .port(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (bus.valid === 1'b1) got.push_back('{bus.data, bus.frame_err, bus.parity_err, bus.busy, cyc});
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask
   // Drives one whole frame starting at the current negedge; records what a receiver must report.
   task automatic send(input logic [7:0] b, input bit stop = 1, input bit bad_par = 0);
      logic [10:0] fr;
      ev_t e;
      fr = PAR ? {stop, (^b) ^ bad_par, b, 1'b0} : {1'b1, stop, b, 1'b0};
      e.d = b;
      e.fe = ~stop;
      e.pe = PAR & bad_par;
      e.bz = ~stop;
      e.t = cyc + 2 + HALF + (NB - 1) * CPB;
      exp_q.push_back(e);
      for (int i = 0; i < NB; i++) begin
         bus.rx = fr[i];
         repeat (CPB) @(negedge clk);
      end
   endtask
   task automatic drain(input string tag);
      ev_t g, e;
      chk({tag, " count"}, got.size(), exp_q.size());
      while (got.size() > 0 && exp_q.size() > 0) begin
         g = got.pop_front();
         e = exp_q.pop_front();
         chk({tag, " data"}, g.d, e.d);
         chk({tag, " frame_err"}, g.fe, e.fe);
         chk({tag, " parity_err"}, g.pe, e.pe);
         chk({tag, " busy@valid"}, g.bz, e.bz);
         chk({tag, " latency"}, (g.t >= e.t - 2 && g.t <= e.t + 2), 1);
      end
      got.delete();
      exp_q.delete();
   endtask
   initial begin
      logic [7:0] v;
      bus.rx = 1;
      repeat (3) @(negedge clk);
      chk("rst data", bus.data, 0);
      chk("rst valid", bus.valid, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst frame_err", bus.frame_err, 0);
      chk("rst parity_err", bus.parity_err, 0);
      reset = 0;
      repeat (5) @(negedge clk);
      bus.rx = 0;
      repeat (4) @(negedge clk);
      chk("glitch busy", bus.busy, 1);
      bus.rx = 1;
      repeat (HALF + 4) @(negedge clk);
      chk("glitch idle", bus.busy, 0);
      chk("glitch data", bus.data, 0);
      drain("glitch");
      send(8'hA5);
      drain("a5");
      send(8'h3C, 0);
      repeat (2 * CPB) @(negedge clk);
      chk("break busy", bus.busy, 1);
      drain("break");
      bus.rx = 1;
      repeat (CPB) @(negedge clk);
      chk("break recover", bus.busy, 0);
      send(8'h81);
      drain("81");
      send(8'h00);
      send(8'hFF);
      drain("b2b");
      v = 8'h5A;
      bus.rx = 0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.rx = v[i];
         repeat (CPB) @(negedge clk);
      end
      reset = 1;
      #1;
      chk("midrst data", bus.data, 0);
      chk("midrst busy", bus.busy, 0);
      chk("midrst valid", bus.valid, 0);
      chk("midrst frame_err", bus.frame_err, 0);
      @(negedge clk);
      reset = 0;
      bus.rx = 1;
      repeat (3 * CPB) @(negedge clk);
      drain("midrst");
      send(8'h5A);
      drain("5a");
      send(8'h07, 1, 0);
      send(8'h07, 1, 1);
      drain("par");
      for (int n = 0; n < 12; n++) begin
         send(8'($urandom), 1, 1'($urandom));
         repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
      end
      drain("rand");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
